// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache -- direct-mapped, read-only instruction cache with one-word frames.
//
// It sits between the fetch stage and the memory arbiter. A lookup hit answers
// combinationally in the same cycle. A miss latches the fetch address and then
// runs a blocking single-word refill through the iREN/iwait handshake. Hit and
// miss counters are kept for performance runs.
//
// Parameters
//   SETS        number of one-word frames (power of two, 2..256)
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   imemREN     fetch request from the datapath
//   imemaddr    fetch byte address (bits [1:0] ignored)
//   ihit        fetch satisfied this cycle
//   imemload    instruction word, 0 when ihit is low
//   iREN        memory read request (high only while refilling)
//   iaddr       word-aligned memory address, 0 when idle
//   iwait       memory busy, read data not valid yet
//   iload       memory read data
//   hit_count   completed hits, wraps modulo 2^32
//   miss_count  refills started, wraps modulo 2^32
// -----------------------------------------------------------------------------
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 30 - IDX;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    // Control state (reset)
    logic [0:0]      state_q,      state_d;
    logic [29:0]     fetch_addr_q, fetch_addr_d;   // word address of the refill
    logic [31:0]     hit_cnt_q,    hit_cnt_d;
    logic [31:0]     miss_cnt_q,   miss_cnt_d;
    logic [SETS-1:0] valid_q;

    // Frame contents (no reset; only meaningful behind a valid bit)
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    // Lookup on the live fetch address
    logic [IDX-1:0]   look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_match;
    logic             miss_start;

    // Refill target, always taken from the latched address
    logic [IDX-1:0]   fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             fill;

    // Byte-offset bits are architecturally ignored.
    logic unused_byte_offset;
    assign unused_byte_offset = ^imemaddr[1:0];

    assign look_idx   = imemaddr[IDX+1:2];
    assign look_tag   = imemaddr[31:IDX+2];
    assign look_match = valid_q[look_idx] && (tag_q[look_idx] == look_tag);

    assign fill_idx   = fetch_addr_q[IDX-1:0];
    assign fill_tag   = fetch_addr_q[29:IDX];

    // Hits are only answered from IDLE; the refilled word is not forwarded
    // during FETCH, so the requester sees it one cycle after the fill edge.
    assign ihit       = (state_q == IDLE) && imemREN && look_match;
    assign miss_start = (state_q == IDLE) && imemREN && !look_match;
    assign fill       = (state_q == FETCH) && !iwait;

    assign imemload   = ihit ? data_q[look_idx] : 32'h0;
    assign iREN       = (state_q == FETCH);
    assign iaddr      = (state_q == FETCH) ? {fetch_addr_q, 2'b00} : 32'h0;

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        if (ihit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (miss_start) begin
                    state_d      = FETCH;
                    fetch_addr_d = imemaddr[31:2];
                    miss_cnt_d   = miss_cnt_q + 32'd1;
                end
            end
            FETCH: begin
                // The refill finishes even if the request was withdrawn or
                // redirected; the new address is looked up back in IDLE.
                if (!iwait) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset mid-refill returns to IDLE asynchronously, which also drops iREN
    // and suppresses the fill on the following edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            if (fill) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache -- self-checking bench for icache (SETS = 16).
// A behavioural memory answers refills after a programmable number of wait
// cycles. Each fetch pushes its expected word and latency onto a scoreboard
// queue; the entry is popped and compared when ihit rises.
// -----------------------------------------------------------------------------
module tb_icache;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_tests;
    int n_fail;
    int wait_n;
    int wcnt;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];

    icache #(.SETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h40) return 32'h2001_0005;
        return (w ^ 32'hDEAD_0000) + 32'h1;
    endfunction

    // Memory model: holds iwait high for wait_n cycles of each request.
    always @(negedge CLK) begin
        if (iREN) begin
            if (wcnt < wait_n) begin
                iwait = 1'b1;
                wcnt  = wcnt + 1;
            end else begin
                iwait = 1'b0;
            end
            iload = mem_word(iaddr);
        end else begin
            wcnt  = 0;
            iwait = 1'b0;
            iload = 32'h0;
        end
    end

    task automatic do_reset();
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // One fetch: drive, wait for ihit, compare against the scoreboard, then
    // let the hit edge pass so exactly one hit is counted.
    task automatic fetch(input logic [31:0] a, input int lat,
                         output int ren_cyc, output bit addr_ok);
        exp_t e;
        int   cyc;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = a;
        sb.push_back('{addr: a, data: mem_word(a), lat: lat});
        cyc     = 0;
        ren_cyc = 0;
        addr_ok = 1'b1;
        #1;
        while (!ihit && cyc < 50) begin
            if (iREN) begin
                ren_cyc++;
                if (iaddr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
            end
            @(negedge CLK);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        n_tests++;
        if (ihit !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_timeout addr=%h ihit=%b expected 1", e.addr, ihit);
        end
        n_tests++;
        if (cyc != e.lat) begin
            n_fail++;
            $display("FAIL latency addr=%h got %0d expected %0d", e.addr, cyc, e.lat);
        end
        n_tests++;
        if (imemload !== e.data) begin
            n_fail++;
            $display("FAIL imemload addr=%h got %h expected %h", e.addr, imemload, e.data);
        end
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
    endtask

    task automatic check_counts(input string tag, input logic [31:0] h, input logic [31:0] m);
        n_tests++;
        if (hit_count !== h) begin
            n_fail++;
            $display("FAIL %s hit_count got %0d expected %0d", tag, hit_count, h);
        end
        n_tests++;
        if (miss_count !== m) begin
            n_fail++;
            $display("FAIL %s miss_count got %0d expected %0d", tag, miss_count, m);
        end
    endtask

    task automatic test_reset();
        int rc;
        bit ok;
        wait_n   = 0;
        RST      = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        @(posedge CLK);
        #1;
        n_tests++;
        if (ihit !== 1'b0 || imemload !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hit ihit=%b imemload=%h expected 0/0", ihit, imemload);
        end
        n_tests++;
        if (iREN !== 1'b0 || iaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem iREN=%b iaddr=%h expected 0/0", iREN, iaddr);
        end
        check_counts("reset", 32'd0, 32'd0);
        @(negedge CLK);
        RST     = 1'b0;
        imemREN = 1'b0;
        fetch(32'h0, 2, rc, ok);
        check_counts("reset_first", 32'd1, 32'd1);
    endtask

    task automatic test_cold_miss();
        int rc;
        bit ok;
        do_reset();
        wait_n = 0;
        fetch(32'h40, 2, rc, ok);
        n_tests++;
        if (rc != 1 || !ok) begin
            n_fail++;
            $display("FAIL cold_iren cycles=%0d addr_ok=%0d expected 1/1", rc, ok);
        end
        check_counts("cold", 32'd1, 32'd1);
    endtask

    task automatic test_conflict();
        int rc;
        bit ok;
        do_reset();
        wait_n = 0;
        fetch(32'h00, 2, rc, ok);
        fetch(32'h40, 2, rc, ok);
        fetch(32'h00, 2, rc, ok);
        check_counts("conflict", 32'd3, 32'd3);
        fetch(32'h04, 2, rc, ok);
        fetch(32'h04, 0, rc, ok);
        fetch(32'h00, 0, rc, ok);
        check_counts("conflict_idx1", 32'd6, 32'd4);
    endtask

    task automatic test_wait_states();
        int rc;
        bit ok;
        do_reset();
        wait_n = 3;
        fetch(32'h100, 5, rc, ok);
        n_tests++;
        if (rc != 4) begin
            n_fail++;
            $display("FAIL wait_iren_cycles got %0d expected 4", rc);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_iaddr_stable got unstable expected %h", 32'h100);
        end
        check_counts("wait", 32'd1, 32'd1);
        wait_n = 0;
    endtask

    task automatic test_addr_change();
        int rc;
        bit ok;
        do_reset();
        wait_n = 1;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h80;
        @(posedge CLK);
        #1;
        n_tests++;
        if (iREN !== 1'b1 || iaddr !== 32'h80) begin
            n_fail++;
            $display("FAIL chg_fetch iREN=%b iaddr=%h expected 1/00000080", iREN, iaddr);
        end
        // Redirect to 0x84 in the first FETCH cycle: 0x80 refill completes,
        // then 0x84 misses and refills (one wait cycle each).
        fetch(32'h84, 5, rc, ok);
        check_counts("chg", 32'd1, 32'd2);
        fetch(32'h80, 0, rc, ok);
        check_counts("chg_old_hit", 32'd2, 32'd2);
        wait_n = 0;
    endtask

    task automatic test_reset_mid_fetch();
        int rc;
        bit ok;
        do_reset();
        wait_n = 3;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'hC0;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        n_tests++;
        if (iREN !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre iREN=%b expected 1", iREN);
        end
        RST = 1'b1;
        #1;
        n_tests++;
        if (iREN !== 1'b0 || iaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_async iREN=%b iaddr=%h expected 0/0", iREN, iaddr);
        end
        imemREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST    = 1'b0;
        wait_n = 0;
        fetch(32'hC0, 2, rc, ok);
        check_counts("rstmid", 32'd1, 32'd1);
    endtask

    task automatic test_back_to_back();
        int          rc;
        bit          ok;
        exp_t        e;
        logic [31:0] addrs [3];
        do_reset();
        wait_n   = 0;
        addrs[0] = 32'h10;
        addrs[1] = 32'h14;
        addrs[2] = 32'h18;
        for (int i = 0; i < 3; i++) fetch(addrs[i], 2, rc, ok);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            imemREN  = 1'b1;
            imemaddr = addrs[i % 3];
            sb.push_back('{addr: addrs[i % 3], data: mem_word(addrs[i % 3]), lat: 0});
            #1;
            e = sb.pop_front();
            n_tests++;
            if (ihit !== 1'b1 || imemload !== e.data) begin
                n_fail++;
                $display("FAIL b2b addr=%h ihit=%b data=%h expected 1/%h", e.addr, ihit, imemload, e.data);
            end
        end
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
        check_counts("b2b", 32'd9, 32'd3);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        wait_n   = 0;
        wcnt     = 0;
        iwait    = 1'b0;
        iload    = 32'h0;
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_wait_states();
        test_addr_change();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
